// File: rtl/mipi_csi_rx_pkg.sv
// Shared types and constants for the CSI-2 receive lane deskew path.
package mipi_csi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    LOCK,
    ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE       = 8'hB8;
  localparam int         ALIGN_DEPTH_DEF = 4;
  localparam int         OFF_W_DEF       = $clog2(ALIGN_DEPTH_DEF);

  // Offset width for a given skew window; never narrower than one bit.
  function automatic int off_width(input int depth);
    return (depth > 1) ? $clog2(depth) : OFF_W_DEF - OFF_W_DEF + 1;
  endfunction

endpackage

// File: rtl/mipi_lane_delay_line.sv
// Per-lane {valid, data} shift register with a runtime tap; tap 0 is the undelayed input.
module mipi_lane_delay_line #(
  parameter int DATA_W = 8,
  parameter int STAGES = 4,
  parameter int TAP_W  = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TAP_W-1:0]  tap_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W:0] line_p [1:STAGES-1];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 1; k < STAGES; k++) line_p[k] <= '0;
    end else begin
      line_p[1] <= {vld_i, data_i};
      for (int k = 2; k < STAGES; k++) line_p[k] <= line_p[k-1];
    end
  end

  always_comb begin
    {vld_o, data_o} = {vld_i, data_i};
    for (int k = 1; k < STAGES; k++) begin
      if (tap_i == TAP_W'(k)) {vld_o, data_o} = line_p[k];
    end
  end

endmodule

// File: rtl/mipi_csi_rx_lane_align.sv
// Deskews CSI-2 byte lanes so all lanes leave together under one valid.
// Define MIPI_ALIGN_ZERO_DATA_EN to force lane_byte_o to zero while lane_valid_o is low.
module mipi_csi_rx_lane_align
  import mipi_csi_rx_pkg::*;
#(
  parameter int MIPI_GEAR   = 8,
  parameter int MIPI_LANES  = 2,
  parameter int ALIGN_DEPTH = ALIGN_DEPTH_DEF
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [MIPI_LANES-1:0]           bytes_valid_i,
  input  logic [MIPI_GEAR*MIPI_LANES-1:0] byte_i,
  output logic                            lane_valid_o,
  output logic [MIPI_GEAR*MIPI_LANES-1:0] lane_byte_o
);

  localparam int W     = MIPI_GEAR * MIPI_LANES;
  localparam int OFF_W = off_width(ALIGN_DEPTH);
  localparam int CNT_W = $clog2(ALIGN_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ALIGN_DEPTH);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [MIPI_LANES-1:0] seen;
  logic [OFF_W-1:0]      off     [MIPI_LANES];
  logic [OFF_W-1:0]      tap_q   [MIPI_LANES];
  logic [OFF_W-1:0]      off_c   [MIPI_LANES];
  logic [OFF_W-1:0]      tap_c   [MIPI_LANES];
  logic [OFF_W-1:0]      tap_sel [MIPI_LANES];
  logic [OFF_W-1:0]      max_off;
  logic [MIPI_LANES-1:0] seen_c;
  logic                  lock_now;
  logic                  take_p0;
  logic [MIPI_LANES-1:0] vld_p0;
  logic [W-1:0]          data_p0;
  logic                  vld_p1;
  logic [W-1:0]          data_p1;

  // Taps are resolved combinationally so the lock cycle already emits aligned data.
  always_comb begin
    seen_c  = seen | bytes_valid_i;
    max_off = '0;
    for (int n = 0; n < MIPI_LANES; n++) begin
      off_c[n] = seen[n] ? off[n] : ((state == IDLE) ? '0 : cnt[OFF_W-1:0]);
      if (off_c[n] > max_off) max_off = off_c[n];
    end
    for (int n = 0; n < MIPI_LANES; n++) begin
      tap_c[n]   = max_off - off_c[n];
      tap_sel[n] = (state == LOCK) ? tap_q[n] : tap_c[n];
    end
    lock_now = (&seen_c) && ((state == IDLE) || ((state == ALIGN) && (cnt < CNT_MAX)));
    take_p0  = (state == LOCK) || lock_now;
  end

  for (genvar n = 0; n < MIPI_LANES; n++) begin : g_lane
    mipi_lane_delay_line #(
      .DATA_W(MIPI_GEAR),
      .STAGES(ALIGN_DEPTH),
      .TAP_W (OFF_W)
    ) u_dly (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .vld_i  (bytes_valid_i[n]),
      .data_i (byte_i[n*MIPI_GEAR +: MIPI_GEAR]),
      .tap_i  (tap_sel[n]),
      .vld_o  (vld_p0[n]),
      .data_o (data_p0[n*MIPI_GEAR +: MIPI_GEAR])
    );
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= '0;
      seen  <= '0;
      for (int n = 0; n < MIPI_LANES; n++) begin
        off[n]   <= '0;
        tap_q[n] <= '0;
      end
    end else begin
      case (state)
        IDLE, ALIGN: begin
          if (lock_now) begin
            state <= LOCK;
            for (int n = 0; n < MIPI_LANES; n++) tap_q[n] <= tap_c[n];
          end else if (state == ALIGN && cnt == CNT_MAX) begin
            state <= ERR;
          end else if (state == ALIGN || (|bytes_valid_i)) begin
            state <= ALIGN;
            cnt   <= cnt + CNT_W'(1);
            seen  <= seen_c;
            for (int n = 0; n < MIPI_LANES; n++) off[n] <= off_c[n];
          end
        end
        LOCK, ERR: begin
          // Offsets clear on the way out so every packet re-measures its skew.
          if (bytes_valid_i == '0 && (state == ERR || vld_p0 == '0)) begin
            state <= IDLE;
            cnt   <= '0;
            seen  <= '0;
            for (int n = 0; n < MIPI_LANES; n++) begin
              off[n]   <= '0;
              tap_q[n] <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: output register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (take_p0) begin
      vld_p1 <= &vld_p0;
`ifdef MIPI_ALIGN_ZERO_DATA_EN
      data_p1 <= (&vld_p0) ? data_p0 : '0;
`else
      data_p1 <= data_p0;
`endif
    end else begin
      vld_p1 <= 1'b0;
`ifdef MIPI_ALIGN_ZERO_DATA_EN
      data_p1 <= '0;
`endif
    end
  end

  assign lane_valid_o = vld_p1;
  assign lane_byte_o  = data_p1;

endmodule

// File: tb/tb_mipi_csi_rx_lane_align.sv
// Bench for mipi_csi_rx_lane_align: directed vector tables plus randomized packets vs. a history-based model.
module tb_mipi_csi_rx_lane_align;
  import mipi_csi_rx_pkg::*;

  localparam int GEAR  = 8;
  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int W     = GEAR * LANES;
  localparam int HIST  = 4096;

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic [LANES-1:0] bytes_valid = '0;
  logic [W-1:0]     byte_in = '0;
  logic             lane_valid;
  logic [W-1:0]     lane_byte;

  always #5 clk = ~clk;

  mipi_csi_rx_lane_align #(
    .MIPI_GEAR  (GEAR),
    .MIPI_LANES (LANES),
    .ALIGN_DEPTH(DEPTH)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .bytes_valid_i(bytes_valid),
    .byte_i       (byte_in),
    .lane_valid_o (lane_valid),
    .lane_byte_o  (lane_byte)
  );

  typedef struct {
    logic [LANES-1:0] v;
    logic [W-1:0]     d;
    logic             ev;
    logic [W-1:0]     ed;
  } vec_t;

  vec_t tbl [$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: input history plus per-packet first-valid cycles.
  logic [LANES-1:0] hv [HIST];
  logic [W-1:0]     hd [HIST];
  int               cyc = 0;
  bit               m_open = 0;
  int               m_start, m_mode, m_tdec;
  int               m_first [LANES];
  int               m_tap   [LANES];
  logic             e_vld = 1'b0;
  logic [W-1:0]     e_data = '0;

  function automatic vec_t mk(input logic [LANES-1:0] v, input logic [W-1:0] d,
                              input logic ev, input logic [W-1:0] ed);
    vec_t r;
    r.v = v; r.d = d; r.ev = ev; r.ed = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_open = 0;
    e_vld  = 1'b0;
    e_data = '0;
  endtask

  // Output after this cycle's edge: a locked packet shows lane n as it was
  // (last_first - first_n) cycles ago; skew of DEPTH or more yields nothing.
  task automatic model_eval(input logic [LANES-1:0] v, input logic [W-1:0] d);
    int   maxf;
    bit   all_seen;
    logic vand;
    bit   anyd;
    int   idx;
    hv[cyc] = v;
    hd[cyc] = d;
    if (!m_open && v != '0) begin
      m_open = 1; m_start = cyc; m_mode = 0;
      for (int n = 0; n < LANES; n++) m_first[n] = -1;
    end
    if (m_open && m_mode == 0) begin
      for (int n = 0; n < LANES; n++) if (v[n] && m_first[n] < 0) m_first[n] = cyc;
      all_seen = 1; maxf = 0;
      for (int n = 0; n < LANES; n++) begin
        if (m_first[n] < 0) all_seen = 0;
        else if (m_first[n] > maxf) maxf = m_first[n];
      end
      if (all_seen && (maxf - m_start) < DEPTH) begin
        m_mode = 1;
        for (int n = 0; n < LANES; n++) m_tap[n] = maxf - m_first[n];
      end else if (cyc - m_start >= DEPTH) begin
        m_mode = 2; m_tdec = cyc;
      end
    end
    e_vld = 1'b0;
    if (m_open && m_mode == 1) begin
      vand = 1'b1; anyd = 0;
      for (int n = 0; n < LANES; n++) begin
        idx  = cyc - m_tap[n];
        vand = vand & hv[idx][n];
        anyd = anyd | hv[idx][n];
        e_data[n*GEAR +: GEAR] = hd[idx][n*GEAR +: GEAR];
      end
      e_vld = vand;
      if (v == '0 && !anyd) m_open = 0;
    end else if (m_open && m_mode == 2) begin
      if (cyc > m_tdec && v == '0) m_open = 0;
    end
    cyc++;
  endtask

  task automatic step(input logic [LANES-1:0] v, input logic [W-1:0] d, input bit cmp, input string tag);
    bytes_valid = v;
    byte_in     = d;
    model_eval(v, d);
    @(posedge clk);
    #1;
    if (cmp) begin
      chk({tag, ".vld"}, W'(lane_valid), W'(e_vld));
      if (e_vld) chk({tag, ".data"}, lane_byte, e_data);
    end
  endtask

  task automatic run_row(input int i);
    step(tbl[i].v, tbl[i].d, 0, "");
    chk($sformatf("tbl[%0d].vld", i), W'(lane_valid), W'(tbl[i].ev));
    if (tbl[i].ev) chk($sformatf("tbl[%0d].data", i), lane_byte, tbl[i].ed);
  endtask

  initial begin
    int s [LANES];
    int e [LANES];
    int len, tot, gap;
    logic [LANES-1:0] v;
    logic [W-1:0]     d;

    // Lane0 leads by 1 (rows 0..8)
    tbl.push_back(mk(2'b01, 16'h00B8, 0, 16'h0000));
    tbl.push_back(mk(2'b11, 16'hB811, 1, 16'hB8B8));
    tbl.push_back(mk(2'b11, 16'h1122, 1, 16'h1111));
    tbl.push_back(mk(2'b11, 16'h2233, 1, 16'h2222));
    tbl.push_back(mk(2'b11, 16'h3344, 1, 16'h3333));
    tbl.push_back(mk(2'b11, 16'h4455, 1, 16'h4444));
    tbl.push_back(mk(2'b11, 16'h5566, 1, 16'h5555));
    tbl.push_back(mk(2'b10, 16'h6677, 1, 16'h6666));
    tbl.push_back(mk(2'b00, 16'h0000, 0, 16'h0000));
    // Lane1 leads by 2, back to back with the previous packet (rows 9..18)
    tbl.push_back(mk(2'b10, 16'hB800, 0, 16'h0000));
    tbl.push_back(mk(2'b10, 16'h1100, 0, 16'h0000));
    tbl.push_back(mk(2'b11, 16'h22B8, 1, 16'hB8B8));
    tbl.push_back(mk(2'b11, 16'h3311, 1, 16'h1111));
    tbl.push_back(mk(2'b11, 16'h4422, 1, 16'h2222));
    tbl.push_back(mk(2'b11, 16'h5533, 1, 16'h3333));
    tbl.push_back(mk(2'b11, 16'h6644, 1, 16'h4444));
    tbl.push_back(mk(2'b01, 16'h7755, 1, 16'h5555));
    tbl.push_back(mk(2'b01, 16'h8866, 1, 16'h6666));
    tbl.push_back(mk(2'b00, 16'h0000, 0, 16'h0000));
    // No skew (rows 19..27)
    tbl.push_back(mk(2'b11, 16'hB8B8, 1, 16'hB8B8));
    tbl.push_back(mk(2'b11, 16'h1111, 1, 16'h1111));
    tbl.push_back(mk(2'b11, 16'h2222, 1, 16'h2222));
    tbl.push_back(mk(2'b11, 16'h3333, 1, 16'h3333));
    tbl.push_back(mk(2'b11, 16'h4444, 1, 16'h4444));
    tbl.push_back(mk(2'b11, 16'h5555, 1, 16'h5555));
    tbl.push_back(mk(2'b11, 16'h6666, 1, 16'h6666));
    tbl.push_back(mk(2'b00, 16'h7777, 0, 16'h0000));
    tbl.push_back(mk(2'b00, 16'h0000, 0, 16'h0000));

    repeat (2) @(posedge clk);
    #1;
    chk("reset.vld", W'(lane_valid), '0);
    chk("reset.data", lane_byte, '0);
    reset_i = 1'b0;
    model_reset();

    for (int i = 0; i < tbl.size(); i++) run_row(i);

    // Skew of exactly DEPTH: nothing valid for the whole packet
    for (int c = 0; c < 4; c++) begin
      step(2'b01, W'($urandom), 1, "ovf");
      chk("ovf.lead", W'(lane_valid), '0);
    end
    for (int c = 0; c < 3; c++) begin
      step(2'b11, W'($urandom), 1, "ovf");
      chk("ovf.both", W'(lane_valid), '0);
    end
    step(2'b10, W'($urandom), 1, "ovf");
    chk("ovf.tail", W'(lane_valid), '0);
    step(2'b00, '0, 1, "ovf");
    step(2'b11, 16'hB8B8, 1, "post_ovf");
    chk("post_ovf.first", lane_byte, 16'hB8B8);
    step(2'b11, 16'h1234, 1, "post_ovf");
    step(2'b00, '0, 1, "post_ovf");

    // Reset in the middle of a lane0-leads packet
    for (int i = 0; i < 5; i++) run_row(i);
    #2;
    bytes_valid = '0;
    reset_i = 1'b1;
    #1;
    chk("midrst.vld", W'(lane_valid), '0);
    chk("midrst.data", lane_byte, '0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    model_reset();
    for (int i = 19; i < 28; i++) run_row(i);

    // Randomized packets, skew 0..DEPTH per lane, ragged tails
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(2, 8);
      gap = $urandom_range(1, 4);
      tot = 0;
      for (int n = 0; n < LANES; n++) begin
        s[n] = $urandom_range(0, DEPTH);
        e[n] = $urandom_range(0, 1);
        if (s[n] + len + e[n] > tot) tot = s[n] + len + e[n];
      end
      for (int c = 0; c < tot + gap; c++) begin
        v = '0;
        d = W'($urandom);
        for (int n = 0; n < LANES; n++) begin
          if (c >= s[n] && c < s[n] + len + e[n]) v[n] = 1'b1;
          if (c == s[n]) d[n*GEAR +: GEAR] = SYNC_BYTE;
        end
        step(v, d, 1, $sformatf("rnd%0d", p));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
